// File: rtl/fetch_unit.sv
// fetch_unit: owns the PC, issues single-outstanding imem fetches and feeds decode through a 2-entry queue
module fetch_unit #(
    parameter int              PC_W     = 32,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
    input  logic            redirect_valid,
    input  logic [PC_W-1:0] redirect_pc,
    output logic            if_valid,
    input  logic            if_ready,
    output logic [31:0]     if_inst,
    output logic [PC_W-1:0] if_pc,
    output logic            halted
);
    typedef enum logic [1:0] {RUN, WAIT, DRAIN, HALTED} state_t;
    state_t          state, state_n;
    logic [PC_W-1:0] pc, tail_pc;
    logic [31:0]     tail_inst;
    logic            tail_v, is_halt, push, pop;
    assign is_halt   = imem_rdata[6:0] == 7'h7F;
    assign push      = state == WAIT && imem_rvalid && !redirect_valid;
    assign pop       = if_valid && if_ready && !redirect_valid;
    assign imem_req  = rst_n && (state == WAIT || (state == RUN && !tail_v));
    assign imem_addr = pc;
    // DRAIN leaves as soon as the stale response lands, even if a new redirect arrives with it
    always_comb begin
        state_n = state;
        case (state)
            RUN:    state_n = (redirect_valid || tail_v) ? RUN : WAIT;
            WAIT:   state_n = redirect_valid ? (imem_rvalid ? RUN : DRAIN) :
                              !imem_rvalid ? WAIT : is_halt ? HALTED : RUN;
            DRAIN:  state_n = imem_rvalid ? RUN : DRAIN;
            HALTED: state_n = redirect_valid ? RUN : HALTED;
            default: state_n = RUN;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RUN;
            pc        <= RESET_PC;
            halted    <= 1'b0;
            if_valid  <= 1'b0;
            if_inst   <= '0;
            if_pc     <= '0;
            tail_v    <= 1'b0;
            tail_inst <= '0;
            tail_pc   <= '0;
        end else begin
            state  <= state_n;
            halted <= state_n == HALTED;
            if (redirect_valid)
                pc <= redirect_pc & ~PC_W'(3);
            else if (push && !is_halt)
                pc <= pc + PC_W'(4);
            if (redirect_valid) begin
                if_valid <= 1'b0;
                tail_v   <= 1'b0;
            end else if (push && pop) begin
                if (tail_v) begin
                    if_inst   <= tail_inst;
                    if_pc     <= tail_pc;
                    tail_inst <= imem_rdata;
                    tail_pc   <= pc;
                end else begin
                    if_inst <= imem_rdata;
                    if_pc   <= pc;
                end
            end else if (push) begin
                if (!if_valid) begin
                    if_inst  <= imem_rdata;
                    if_pc    <= pc;
                    if_valid <= 1'b1;
                end else begin
                    tail_inst <= imem_rdata;
                    tail_pc   <= pc;
                    tail_v    <= 1'b1;
                end
            end else if (pop) begin
                if (tail_v) begin
                    if_inst <= tail_inst;
                    if_pc   <= tail_pc;
                    tail_v  <= 1'b0;
                end else begin
                    if_valid <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: scoreboard bench with a variable-latency imem model and a narrow-PC wrap instance
module tb_fetch_unit;
    logic        clk = 1'b0, rst_n = 1'b0, rst2_n = 1'b0;
    logic        imem_req, imem_rvalid, redirect_valid, if_valid, if_ready, halted;
    logic [31:0] imem_addr, imem_rdata, redirect_pc, if_inst, if_pc;
    logic        req2, rvalid2, valid2, halted2;
    logic [7:0]  addr2, pc2;
    logic [31:0] inst2;
    logic        busy;
    int          cnt, lat = 1;
    logic [31:0] addr_l, halt_at = 32'hFFFF_FFFF;
    logic [31:0] exp_addr[$];
    logic [63:0] exp_out[$];
    logic [7:0]  q2[$];
    int          n_cmp = 0, n_err = 0, n_req = 0, cyc = 0, last_pop = -1;
    bit          gap_en = 0;

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .if_valid(if_valid), .if_ready(if_ready), .if_inst(if_inst), .if_pc(if_pc),
        .halted(halted)
    );

    fetch_unit #(.PC_W(8), .RESET_PC(8'hFC)) dut2 (
        .clk(clk), .rst_n(rst2_n), .imem_req(req2), .imem_addr(addr2),
        .imem_rvalid(rvalid2), .imem_rdata(32'h13),
        .redirect_valid(1'b0), .redirect_pc(8'h00),
        .if_valid(valid2), .if_ready(1'b1), .if_inst(inst2), .if_pc(pc2),
        .halted(halted2)
    );

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return (a == halt_at) ? 32'h0000_007F : {a[23:0], 8'h13};
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // memory: lat cycles from the request cycle to the rvalid cycle
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy        <= 1'b0;
            cnt         <= 0;
            imem_rvalid <= 1'b0;
            imem_rdata  <= '0;
        end else begin
            imem_rvalid <= 1'b0;
            if (busy) begin
                if (cnt == 1) begin
                    imem_rvalid <= 1'b1;
                    imem_rdata  <= inst_of(addr_l);
                    busy        <= 1'b0;
                end else cnt <= cnt - 1;
            end else if (imem_req && !imem_rvalid) begin
                if (lat == 1) begin
                    imem_rvalid <= 1'b1;
                    imem_rdata  <= inst_of(imem_addr);
                end else begin
                    busy   <= 1'b1;
                    cnt    <= lat - 1;
                    addr_l <= imem_addr;
                end
            end
        end
    end

    always @(posedge clk or negedge rst2_n)
        if (!rst2_n) rvalid2 <= 1'b0;
        else rvalid2 <= req2 && !rvalid2;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (rst_n) begin
            if (imem_req && !busy && !imem_rvalid) begin
                n_req++;
                if (exp_addr.size() == 0) chk("addr_extra", exp_addr.size(), 1);
                else chk("imem_addr", imem_addr, exp_addr.pop_front());
            end
            if (if_valid && if_ready && !redirect_valid) begin
                if (exp_out.size() == 0) chk("out_extra", exp_out.size(), 1);
                else chk("if_pc_inst", {if_pc, if_inst}, exp_out.pop_front());
                if (gap_en && last_pop >= 0) chk("gap", cyc - last_pop, 2);
                last_pop = cyc;
            end
        end
    end

    always @(negedge clk)
        if (rst2_n && req2 && !rvalid2 && q2.size() < 2) q2.push_back(addr2);

    task automatic do_reset();
        rst_n = 1'b0;
        redirect_valid = 1'b0;
        exp_addr.delete();
        exp_out.delete();
        n_req = 0;
        last_pop = -1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req", imem_req, 0);
        chk("rst_valid", if_valid, 0);
        chk("rst_halted", halted, 0);
        chk("rst_pc_inst", {if_pc, if_inst}, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic exp_run(input int s, input int e);
        for (int a = s; a <= e; a += 4) begin
            exp_addr.push_back(32'(a));
            exp_out.push_back({32'(a), inst_of(32'(a))});
        end
    endtask

    task automatic wait_halt();
        int t = 0;
        while (!(halted && exp_out.size() == 0) && t < 300) begin
            @(negedge clk);
            t++;
        end
        chk("halt_reached", halted, 1);
        chk("out_left", exp_out.size(), 0);
        chk("addr_left", exp_addr.size(), 0);
    endtask

    task automatic wait_req();
        int t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!imem_req && t < 50);
        chk("req_seen", imem_req, 1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        if_ready = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        // straight-line fetch, 1-cycle memory, full throughput
        halt_at = 32'h18;
        lat = 1;
        do_reset();
        rst2_n = 1'b1;
        exp_run(0, 'h18);
        gap_en = 1;
        wait_halt();
        gap_en = 0;
        chk("wrap_n", q2.size(), 2);
        if (q2.size() == 2) begin
            chk("wrap_first", q2[0], 8'hFC);
            chk("wrap_next", q2[1], 8'h00);
        end
        // decode stall fills both entries
        halt_at = 32'h28;
        if_ready = 1'b0;
        do_reset();
        exp_run(0, 'h28);
        repeat (10) @(negedge clk);
        chk("stall_valid", if_valid, 1);
        chk("stall_req", imem_req, 0);
        chk("stall_nreq", n_req, 2);
        @(posedge clk);
        #1 if_ready = 1'b1;
        wait_halt();
        // redirect while waiting on a slow response
        halt_at = 32'h108;
        lat = 3;
        do_reset();
        exp_addr.push_back(0);
        exp_run('h100, 'h108);
        wait_req();
        redirect_valid = 1'b1;
        redirect_pc = 32'h103;
        @(posedge clk);
        #1 redirect_valid = 1'b0;
        chk("drain_req", imem_req, 0);
        chk("drain_valid", if_valid, 0);
        chk("drain_addr", imem_addr, 'h100);
        wait_halt();
        // redirect coincident with the response
        halt_at = 32'h208;
        lat = 1;
        do_reset();
        exp_addr.push_back(0);
        exp_run('h200, 'h208);
        wait_req();
        chk("rsp_same_cycle", imem_rvalid, 1);
        redirect_valid = 1'b1;
        redirect_pc = 32'h200;
        @(posedge clk);
        #1 redirect_valid = 1'b0;
        chk("flush_valid", if_valid, 0);
        chk("redir_req", imem_req, 1);
        chk("redir_addr", imem_addr, 'h200);
        wait_halt();
        // halt at 0x0C, then restart by redirect
        halt_at = 32'h0C;
        do_reset();
        exp_run(0, 'h0C);
        wait_halt();
        repeat (4) @(negedge clk);
        chk("halt_hold", halted, 1);
        chk("halt_noreq", imem_req, 0);
        chk("halt_nreq", n_req, 4);
        halt_at = 32'h44;
        exp_run('h40, 'h44);
        @(posedge clk);
        #1;
        redirect_valid = 1'b1;
        redirect_pc = 32'h40;
        @(posedge clk);
        #1 redirect_valid = 1'b0;
        chk("unhalt", halted, 0);
        chk("unhalt_addr", imem_addr, 'h40);
        wait_halt();
        chk("dut2_running", {halted2, valid2 | ~valid2, pc2[1:0], inst2[6:0]}, {1'b0, 1'b1, 2'b00, 7'h13});
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
